// File: rtl/i2c_arb_pkg.sv
// ----------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C bus arbiter, the byte-level engine and the
// client sequencers that sit on top of it.
//   - i2c_inst_e   : engine instruction codes (START/STOP/READ/WRITE)
//   - arb_state_e  : arbiter FSM state encoding
//   - HOLD_CNT_W   : width of the per-grant hold watchdog counter
//   - idx_width()  : index width for a requester count (at least 1 bit)
// Optional feature macro: I2C_ARB_AUTOSTOP_EN adds the AUTOSTOP state.
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        INST_START = 2'd0,
        INST_STOP  = 2'd1,
        INST_READ  = 2'd2,
        INST_WRITE = 2'd3
    } i2c_inst_e;

`ifdef I2C_ARB_AUTOSTOP_EN
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANTED  = 2'd1,
        ARB_RELEASE  = 2'd2,
        ARB_AUTOSTOP = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;
`endif

    localparam int HOLD_CNT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// i2c_bus_arbiter_if
// Bundles the client-side and engine-side signals of the I2C bus arbiter.
//   Client side : req, grant, cli_instruction, cli_enable, cli_byte_to_send,
//                 cli_complete, cli_byte_received (client i uses slice i)
//   Engine side : i2c_instruction, i2c_enable, i2c_byte_to_send,
//                 i2c_byte_received, i2c_complete
// Modports:
//   master : the arbiter (drives grant/cli_complete and the engine command)
//   slave  : the clients plus engine (drive requests and engine responses)
// ----------------------------------------------------------------------------
interface i2c_bus_arbiter_if #(
    parameter int REQUESTERS = 2
);

    logic [REQUESTERS-1:0]   req;
    logic [REQUESTERS-1:0]   grant;
    logic [2*REQUESTERS-1:0] cli_instruction;
    logic [REQUESTERS-1:0]   cli_enable;
    logic [8*REQUESTERS-1:0] cli_byte_to_send;
    logic [REQUESTERS-1:0]   cli_complete;
    logic [7:0]              cli_byte_received;

    logic [1:0]              i2c_instruction;
    logic                    i2c_enable;
    logic [7:0]              i2c_byte_to_send;
    logic [7:0]              i2c_byte_received;
    logic                    i2c_complete;

    modport master (
        input  req, cli_instruction, cli_enable, cli_byte_to_send,
               i2c_byte_received, i2c_complete,
        output grant, cli_complete, cli_byte_received,
               i2c_instruction, i2c_enable, i2c_byte_to_send
    );

    modport slave (
        output req, cli_instruction, cli_enable, cli_byte_to_send,
               i2c_byte_received, i2c_complete,
        input  grant, cli_complete, cli_byte_received,
               i2c_instruction, i2c_enable, i2c_byte_to_send
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches eligible requests
// (req_i & ~mask_i) starting at last_i+1 and wrapping at N-1 -> 0.
//   req_i      : request vector
//   last_i     : index of the most recent grant
//   mask_i     : requests to ignore (recently revoked clients)
//   pick_o     : one-hot selection, zero when nothing is eligible
//   pick_idx_o : binary index of pick_o
//   valid_o    : a selection was made
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] pick_idx_o,
    output logic          valid_o
);

    logic [N-1:0] elig;

    assign elig = req_i & ~mask_i;

    // NOTE: every output gets a default before the search loop so that no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        valid_o    = 1'b0;
        // k = N brings the search back to last_i itself, so a lone
        // requester can be re-granted.
        for (int k = 1; k <= N; k++) begin
            if (!valid_o && elig[(int'(last_i) + k) % N]) begin
                valid_o                          = 1'b1;
                pick_o[(int'(last_i) + k) % N]   = 1'b1;
                pick_idx_o                       = IW'((int'(last_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one byte-level I2C engine between REQUESTERS clients. Grants are
// round-robin and locked from grant until the owner drops req with no engine
// operation in flight. A hold watchdog revokes a grant held for HOLD_MAX
// cycles while the engine is idle, and masks the revoked client until its
// req has been seen low. Every change of owner has at least one cycle with
// grant == 0.
// Ports:
//   clk          : engine clock
//   rst_n        : asynchronous active-low reset
//   bus          : i2c_bus_arbiter_if.master (client requests/fields,
//                  engine command/response)
//   hold_timeout : one-cycle pulse when the watchdog revokes a grant
// Optional feature macro: I2C_ARB_AUTOSTOP_EN -- when defined, a release or
// revocation with the bus still open issues a STOP (AUTOSTOP state) before
// the next owner is granted.
// ----------------------------------------------------------------------------
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int                    REQUESTERS = 2,
    parameter logic [HOLD_CNT_W-1:0] HOLD_MAX   = 16'd60000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_bus_arbiter_if.master     bus,
    output logic                  hold_timeout
);

    localparam int IW = idx_width(REQUESTERS);

    arb_state_e              state_q;
    logic [REQUESTERS-1:0]   grant_q;
    logic [REQUESTERS-1:0]   mask_q;
    logic [IW-1:0]           last_q;      // also the current owner's index
    logic [HOLD_CNT_W-1:0]   hold_cnt_q;
    logic [HOLD_CNT_W-1:0]   hold_cnt_d;
    logic                    hold_timeout_q;

    logic [REQUESTERS-1:0]   pick;
    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;
    logic                    release_now;
    logic                    wd_fire;

    rr_arbiter #(.N(REQUESTERS)) u_rr (
        .req_i      (bus.req),
        .last_i     (last_q),
        .mask_i     (mask_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

`ifdef I2C_ARB_AUTOSTOP_EN
    logic bus_open_q;
    logic complete_q;
    logic cpl_rise;

    assign cpl_rise = bus.i2c_complete & ~complete_q;

    // Tracks whether a START has completed without a matching STOP, so a
    // departing owner cannot leave the bus claimed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_open_q <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= bus.i2c_complete;
            if (cpl_rise && bus.i2c_instruction == INST_START) begin
                bus_open_q <= 1'b1;
            end else if (cpl_rise && bus.i2c_instruction == INST_STOP) begin
                bus_open_q <= 1'b0;
            end
        end
    end
`endif

    // Engine mux is combinational from the grant register so that an async
    // reset removes the enable in the same cycle.
    always_comb begin
        bus.i2c_instruction  = INST_START;
        bus.i2c_enable       = 1'b0;
        bus.i2c_byte_to_send = '0;
        if (|grant_q) begin
            bus.i2c_instruction  = bus.cli_instruction[2*int'(last_q) +: 2];
            bus.i2c_enable       = bus.cli_enable[last_q];
            bus.i2c_byte_to_send = bus.cli_byte_to_send[8*int'(last_q) +: 8];
        end
`ifdef I2C_ARB_AUTOSTOP_EN
        else if (state_q == ARB_AUTOSTOP) begin
            bus.i2c_instruction = INST_STOP;
            bus.i2c_enable      = 1'b1;
        end
`endif
    end

    assign bus.grant             = grant_q;
    assign bus.cli_complete      = {REQUESTERS{bus.i2c_complete}} & grant_q;
    assign bus.cli_byte_received = bus.i2c_byte_received;
    assign hold_timeout          = hold_timeout_q;

    assign hold_cnt_d  = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

    // The engine enable gates both exits: an operation in flight is never
    // cut off, whether by a late req drop or by the watchdog.
    assign release_now = (state_q == ARB_GRANTED) && !bus.req[last_q] && !bus.i2c_enable;
    assign wd_fire     = (state_q == ARB_GRANTED) && !release_now &&
                         (hold_cnt_q == HOLD_MAX) && !bus.i2c_enable;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and later assignments in the block
    // (e.g. the mask on revocation) override earlier defaults cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            grant_q        <= '0;
            mask_q         <= '0;
            last_q         <= IW'(REQUESTERS - 1);
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            hold_timeout_q <= 1'b0;
            // A revoked client is unmasked once its req has been seen low.
            mask_q         <= mask_q & bus.req;

            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick;
                        last_q     <= pick_idx;
                        hold_cnt_q <= '0;
                        state_q    <= ARB_GRANTED;
                    end
                end

                ARB_GRANTED: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (release_now || wd_fire) begin
                        grant_q <= '0;
                        if (wd_fire) begin
                            hold_timeout_q <= 1'b1;
                            mask_q         <= (mask_q & bus.req) | grant_q;
                        end
`ifdef I2C_ARB_AUTOSTOP_EN
                        state_q <= bus_open_q ? ARB_AUTOSTOP : ARB_RELEASE;
`else
                        state_q <= ARB_RELEASE;
`endif
                    end
                end

                ARB_RELEASE: begin
                    state_q <= ARB_IDLE;
                end

`ifdef I2C_ARB_AUTOSTOP_EN
                ARB_AUTOSTOP: begin
                    // Enable drops with the state change, one cycle after
                    // the engine reports the STOP complete.
                    if (bus.i2c_complete) begin
                        state_q <= ARB_RELEASE;
                    end
                end
`endif

                default: begin
                    grant_q <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed bench for i2c_bus_arbiter (REQUESTERS=2, HOLD_MAX=100) with a
// small behavioural engine that completes each enabled operation after three
// cycles. Build with +define+I2C_ARB_AUTOSTOP_EN to include the AUTOSTOP
// sequence.
// ----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic hold_timeout;

    i2c_bus_arbiter_if #(.REQUESTERS(2)) bus ();

    i2c_bus_arbiter #(
        .REQUESTERS (2),
        .HOLD_MAX   (16'd100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .hold_timeout (hold_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- engine model ----------------
    int         eng_cnt = 0;
    int         eng_ops = 0;
    logic [1:0] eng_last_inst = 2'd0;
    logic [7:0] eng_last_byte = 8'd0;

    always @(negedge clk) begin
        if (!rst_n || !bus.i2c_enable) begin
            bus.i2c_complete <= 1'b0;
            eng_cnt = 0;
        end else if (!bus.i2c_complete) begin
            eng_cnt++;
            if (eng_cnt == 3) begin
                bus.i2c_complete      <= 1'b1;
                bus.i2c_byte_received <= 8'hC3;
                eng_last_inst         <= bus.i2c_instruction;
                eng_last_byte         <= bus.i2c_byte_to_send;
                eng_ops               <= eng_ops + 1;
            end
        end
    end

    // ---------------- invariant monitors ----------------
    int         leak_cnt    = 0;
    int         overlap_cnt = 0;
    logic [1:0] prev_g      = 2'b00;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus.cli_complete & ~bus.grant) != 2'b00) leak_cnt++;
            if ($countones(bus.grant) > 1) overlap_cnt++;
            if (bus.grant != 2'b00 && prev_g != 2'b00 && bus.grant != prev_g) overlap_cnt++;
            prev_g = bus.grant;
        end else begin
            prev_g = 2'b00;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] exp, input string tag);
        int n = 0;
        while (bus.grant == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus.grant, exp);
    endtask

    task automatic op(input int c, input logic [1:0] inst, input logic [7:0] data, input string tag);
        int n = 0;
        bus.cli_instruction[2*c +: 2]  = inst;
        bus.cli_byte_to_send[8*c +: 8] = data;
        bus.cli_enable[c]              = 1'b1;
        while (!bus.cli_complete[c] && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done"}, bus.cli_complete[c], 1'b1);
        bus.cli_enable[c] = 1'b0;
        tick();
        check({tag, "_inst"}, eng_last_inst, inst);
        check({tag, "_byte"}, eng_last_byte, data);
    endtask

    task automatic txn(input int c, input string tag);
        op(c, INST_START, 8'h00, {tag, "_start"});
        op(c, INST_WRITE, 8'h40, {tag, "_write"});
        op(c, INST_STOP,  8'h00, {tag, "_stop"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.req              = 2'b00;
        bus.cli_enable       = 2'b00;
        bus.cli_instruction  = '0;
        bus.cli_byte_to_send = '0;
        rst_n                = 1'b0;

        // Reset state
        #12;
        check("rst_grant",    bus.grant, 2'b00);
        check("rst_enable",   bus.i2c_enable, 1'b0);
        check("rst_inst",     bus.i2c_instruction, 2'd0);
        check("rst_byte",     bus.i2c_byte_to_send, 8'h00);
        check("rst_complete", bus.cli_complete, 2'b00);
        check("rst_timeout",  hold_timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_grant", bus.grant, 2'b00);

        // Round-robin: last resets to 1, so client 0 goes first
        bus.req = 2'b11;
        wait_grant(2'b01, "rr_first");
        txn(0, "rr0");
        bus.req[0] = 1'b0;
        tick();
        check("rr_gap0", bus.grant, 2'b00);
        bus.req[0] = 1'b1;
        wait_grant(2'b10, "rr_second");
        txn(1, "rr1");
        bus.req[1] = 1'b0;
        tick();
        check("rr_gap1", bus.grant, 2'b00);
        wait_grant(2'b01, "rr_third");
        txn(0, "rr0b");
        bus.req[0] = 1'b0;
        repeat (3) tick();
        check("rr_idle", bus.grant, 2'b00);

        // Isolation: client 1 enable must never reach the engine
        bus.req[0] = 1'b1;
        wait_grant(2'b01, "iso_grant");
        bus.cli_instruction[3:2]  = INST_WRITE;
        bus.cli_byte_to_send[15:8] = 8'h77;
        bus.cli_enable[1] = 1'b1;
        tick();
        check("iso_enable", bus.i2c_enable, 1'b0);
        bus.cli_enable[1] = 1'b0;
        tick();
        bus.cli_enable[1] = 1'b1;
        op(0, INST_START, 8'h00, "iso_start");
        op(0, INST_WRITE, 8'h12, "iso_write");
        op(0, INST_READ,  8'h00, "iso_read");
        check("iso_rx", bus.cli_byte_received, 8'hC3);
        op(0, INST_STOP,  8'h00, "iso_stop");
        check("iso_cpl1", bus.cli_complete[1], 1'b0);
        bus.cli_enable[1] = 1'b0;
        bus.req[0] = 1'b0;
        repeat (3) tick();

        // Late release: req drops while a WRITE is in flight
        bus.req[0] = 1'b1;
        wait_grant(2'b01, "late_grant");
        bus.cli_instruction[1:0]  = INST_WRITE;
        bus.cli_byte_to_send[7:0] = 8'h5A;
        bus.cli_enable[0] = 1'b1;
        tick();
        bus.req[0] = 1'b0;
        tick();
        check("late_hold", bus.grant, 2'b01);
        n = 0;
        while (!bus.cli_complete[0] && n < 40) begin
            tick();
            n++;
        end
        check("late_done", bus.cli_complete[0], 1'b1);
        check("late_hold2", bus.grant, 2'b01);
        bus.cli_enable[0] = 1'b0;
        tick();
        check("late_rel", bus.grant, 2'b00);
        check("late_wbyte", eng_last_byte, 8'h5A);
        repeat (2) tick();

        // Watchdog: client 0 idles on the bus, client 1 waiting
        bus.req = 2'b01;
        wait_grant(2'b01, "wd_grant");
        bus.req[1] = 1'b1;
        n = 0;
        while (!hold_timeout && n < 200) begin
            tick();
            n++;
        end
        check("wd_cycles", n, 101);
        check("wd_revoked", bus.grant, 2'b00);
        tick();
        check("wd_pulse", hold_timeout, 1'b0);
        wait_grant(2'b10, "wd_next");
        bus.req[1] = 1'b0;
        repeat (5) tick();
        check("wd_masked", bus.grant, 2'b00);
        bus.req[0] = 1'b0;
        tick();
        bus.req[0] = 1'b1;
        wait_grant(2'b01, "wd_unmask");
        bus.req[0] = 1'b0;
        repeat (3) tick();

`ifdef I2C_ARB_AUTOSTOP_EN
        // AUTOSTOP: client 0 leaves after START without STOP
        bus.req[0] = 1'b1;
        wait_grant(2'b01, "as_grant");
        op(0, INST_START, 8'h00, "as_start");
        bus.req[0] = 1'b0;
        tick();
        check("as_grant0", bus.grant, 2'b00);
        check("as_enable", bus.i2c_enable, 1'b1);
        check("as_inst", bus.i2c_instruction, INST_STOP);
        n = eng_ops;
        while (eng_ops == n && n < 1000) begin
            tick();
            check("as_wait_grant", bus.grant, 2'b00);
            if (eng_ops == n && !bus.i2c_enable) break;
        end
        check("as_stop", eng_last_inst, INST_STOP);
        repeat (2) tick();
        check("as_enable_off", bus.i2c_enable, 1'b0);
        check("as_grant_end", bus.grant, 2'b00);
`endif

        // Asynchronous reset in the middle of a granted operation
        bus.req[0] = 1'b1;
        wait_grant(2'b01, "rst_mid_grant");
        bus.cli_instruction[1:0] = INST_WRITE;
        bus.cli_enable[0] = 1'b1;
        tick();
        check("rst_mid_en_pre", bus.i2c_enable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_grant0", bus.grant, 2'b00);
        check("rst_mid_enable", bus.i2c_enable, 1'b0);
        check("rst_mid_timeout", hold_timeout, 1'b0);
        bus.req        = 2'b00;
        bus.cli_enable = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        check("rst_after", bus.grant, 2'b00);

        check("leak", leak_cnt, 0);
        check("overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C engine between REQUESTERS clients, e.g. the PCF8574 expander sequencer and an ADC poller on the same SDA/SCL pair.
- Engine interface: instruction (START/STOP/READ/WRITE) plus an enable/complete handshake.
- Round-robin grant, locked for a whole transaction (START…STOP).
- Per-grant hold watchdog. Sits between the clients' sequencers and the engine, on the engine's slow clock.

Parameters:
- REQUESTERS, 2: number of clients (1..8).
- HOLD_MAX, 16'd60000: maximum clk cycles a grant may be held before forced revocation.

Ports:
- clk  input  1  engine clock (same clock as the engine).
- rst_n  input  1  asynchronous, active-low reset.
- req  input  REQUESTERS  client i requests the bus; held for the whole transaction.
- grant  output  REQUESTERS  one-hot or zero; client i owns the engine.
- cli_instruction  input  2*REQUESTERS  client i uses bits [2i+1:2i].
- cli_enable  input  REQUESTERS  client operation enable, held until complete.
- cli_byte_to_send  input  8*REQUESTERS  client i uses bits [8i+7:8i].
- cli_complete  output  REQUESTERS  engine complete routed to the granted client only.
- cli_byte_received  output  8  engine received byte, broadcast to all clients.
- i2c_instruction  output  2  to engine.
- i2c_enable  output  1  to engine.
- i2c_byte_to_send  output  8  to engine.
- i2c_byte_received  input  8  from engine.
- i2c_complete  input  1  from engine.
- hold_timeout  output  1  one-cycle pulse when HOLD_MAX revokes a grant.

Behaviour:
- Instruction codes: START=0, STOP=1, READ=2, WRITE=3.
- Reset (async assert, sync release): state=IDLE, grant=0, last=REQUESTERS-1, hold counter=0, bus_open=0, hold_timeout=0. i2c_enable=0, i2c_instruction=0, i2c_byte_to_send=0. cli_complete=0.
- States: IDLE, GRANTED, RELEASE (plus AUTOSTOP under the optional feature).
- IDLE: if any req, grant the first set req searching from last+1 with wrap (index REQUESTERS-1 wraps to 0). The grant register is set on the next edge, so latency from req is 1 cycle. Set last to the granted index, clear the hold counter, go to GRANTED. With no req, stay in IDLE.
- GRANTED, engine muxing (combinational from the grant register):
  - i2c_instruction, i2c_enable and i2c_byte_to_send equal the granted client's fields.
  - cli_complete[i] = i2c_complete & grant[i].
  - Non-granted clients' cli_enable is ignored and never reaches the engine.
- bus_open: set on the cycle i2c_complete rises with instruction START; cleared when it rises with STOP.
- Hold counter: increments every cycle in GRANTED and saturates at HOLD_MAX.
- Release:
  - Trigger: req[g]==0 and i2c_enable==0 → RELEASE.
  - If req drops while cli_enable[g] is high, the grant holds until that enable falls. An in-flight engine operation is never cut off.
- Watchdog:
  - Trigger: counter==HOLD_MAX and i2c_enable==0 → pulse hold_timeout for 1 cycle, go to RELEASE even though req[g] is still high.
  - A revoked client must drop req before it can be granted again; a set req on a just-revoked index is masked until it has been seen low.
- RELEASE: grant=0 for exactly 1 cycle, then IDLE. This guarantees a grant gap between owners (no back-to-back overlap).
- Simultaneous requests: round-robin order only; no fixed priority.
- REQUESTERS=1 degenerates to a pass-through with the watchdog still active.
- Reset mid-transaction: grant and i2c_enable drop immediately. The engine is reset by the same rst_n domain owner; bus recovery is the next client's START.

Optional Feature:
- Macro: I2C_ARB_AUTOSTOP_EN.
- Defined: on release or revocation with bus_open=1, enter AUTOSTOP instead of RELEASE.
  - Drive i2c_instruction=STOP and i2c_enable=1, with grant=0.
  - Wait for i2c_complete, drop i2c_enable, then go to RELEASE.
  - The bus is always left idle between owners.
- Undefined: no AUTOSTOP state and no bus_open logic. A client that releases without STOP leaves the bus open, and that is its own fault.

Decomposition:
- Shared package i2c_arb_pkg: INST_START/STOP/READ/WRITE codes (also used by the engine and pcf8574 sequencer), arbiter state encoding, hold-counter width (16).
- Sub-module rr_arbiter: purely combinational round-robin picker. Inputs req, last, mask; outputs one-hot pick and its index.

Test Plan:
- Reset: rst_n low mid-GRANTED → grant=0, i2c_enable=0, hold_timeout=0 within the same cycle (async).
- Round-robin: req=2'b11 held; each client runs START, WRITE 0x40, STOP, then drops req → grants alternate 01,10,01 with ≥1-cycle zero gap.
- Isolation: client1 toggles cli_enable while client0 is granted → i2c_enable follows client0 only; cli_complete[1] stays 0.
- Late release: client0 drops req while its WRITE is in flight → grant held until cli_enable[0] falls, then RELEASE.
- Watchdog: HOLD_MAX=100, client0 holds req with no activity → hold_timeout pulse at cycle 100, grant to client1 if requesting, client0 masked until its req is seen low.
- AUTOSTOP (macro defined): client0 does START then drops req → engine sees STOP, enable held until complete, grant stays 0 until RELEASE.
